wm8731_i2c_config: RTL and testbench
====================================

Name: wm8731_i2c_config

Overview:
- Sequences the one-time I2C configuration of the WM8731 audio codec that feeds the SOPC audio conduit (XCK/BCLK/DACLRC/DACDAT).
- Walks a fixed 10-entry register table and issues one I2C write per entry: device address, then a 16-bit register word.
- Checks the slave ACK after every byte and retries an entry on NACK.
- Reports busy/done/error status so the Nios side, or the LEDG pins, can gate audio start-up.

Parameters:
- CLK_DIV, 125, clk cycles per quarter SCL period (50 MHz / (4 × 100 kHz)); must be ≥ 2.
- DEV_ADDR, 7'h1A, 7-bit codec address; the first byte on the wire is 8'h34.
- MAX_RETRY, 3, attempts per table entry before error.
- GAP_CYC, 500, idle clk cycles between the STOP of one entry and the START of the next.

Ports:
- clk  in  1  50 MHz system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; (re)runs the full sequence; ignored while busy
- sda_in  in  1  sampled SDA pad value, synchronised externally
- scl_out  out  1  SCL drive (push-pull; the codec never stretches the clock)
- sda_oe  out  1  1 = drive SDA low; 0 = release (pad pulled high)
- busy  out  1  sequence in progress
- done  out  1  sticky; all 10 entries ACKed
- error  out  1  sticky; an entry exhausted MAX_RETRY
- err_index  out  4  table index of the failing entry, valid when error=1

Behaviour:
- Reset:
  - scl_out=1, sda_oe=0, busy=0, done=0, error=0, err_index=0, state=IDLE, index=0, retry count=0.
  - Reset release auto-arms one run, exactly as if start had been pulsed on the first cycle after reset.
  - Reset asserted mid-transfer aborts immediately with the same outputs (bus released).
- Tick: a free-running divider produces a 1-cycle qtick every CLK_DIV clks. All I2C state changes occur only on qtick. The divider resets to 0 on entry to START.
- Table (word = {reg[6:0], data[8:0]}), in this order:
  - 0: R15 = 9'h000 (reset)
  - 1: R0 = 9'h017
  - 2: R1 = 9'h017
  - 3: R2 = 9'h079
  - 4: R3 = 9'h079
  - 5: R4 = 9'h012
  - 6: R5 = 9'h000
  - 7: R6 = 9'h000
  - 8: R7 = 9'h042 (master, I2S, 16-bit)
  - 9: R9 = 9'h001 (active)
- States:
  - IDLE: scl_out=1, sda_oe=0. Leaves on start or auto-arm: busy=1, done=0, error=0, index=0, retry=0, go to START.
  - START (4 qticks): q0 SDA released, SCL high; q1 sda_oe=1 (START condition); q2 SCL low; q3 load byte 0 → BYTE.
  - BYTE: 8 bits, MSB first, 4 qticks per bit.
    - q0: SCL low, sda_oe = ~bit.
    - q1: hold.
    - q2: SCL high.
    - q3: hold, then shift.
    - After the 8th bit → ACK.
  - ACK: q0 SCL low, sda_oe=0; q1 hold; q2 SCL high; q3 sample sda_in.
    - sda_in=0 (ACK): byte<2 → next byte, BYTE; byte=2 → STOP (success).
    - sda_in=1 (NACK) → STOP (fail).
  - STOP: q0 SCL low, sda_oe=1; q1 hold; q2 SCL high; q3 sda_oe=0 (STOP condition) → GAP.
  - GAP: count GAP_CYC clks. Then:
    - last write succeeded, index=9 → DONE.
    - last write succeeded, index<9 → index+1, retry=0, START.
    - last write failed, retry+1 < MAX_RETRY → retry+1, START with the same index.
    - last write failed, retry+1 = MAX_RETRY → ERROR with err_index=index.
  - DONE: busy=0, done=1 → IDLE.
  - ERROR: busy=0, error=1 → IDLE.
- Byte order per entry: DEV_ADDR,0 (R/W=0); word[15:8]; word[7:0].
- start while busy is dropped (no queueing). start coincident with the auto-arm cycle collapses to a single run.
- SDA changes only while SCL is low, except the START/STOP edges. Bus timing follows from the 4-qtick bit cell.
- Transaction length: 1 + 27 bit cells + 1 STOP = 116 qticks, plus GAP_CYC clks.

Test Plan:
- Release reset with an always-ACK slave model → 10 transactions. Decoded bytes: 34 1E 00, 34 00 17, 34 02 17, 34 04 79, 34 06 79, 34 08 12, 34 0A 00, 34 0C 00, 34 0E 42, 34 12 01. Then busy=0, done=1, error=0.
- Slave NACKs the second byte of entry 3 once, then ACKs → entry 3 is sent twice, sequence completes, done=1.
- Slave NACKs every address byte of entry 5 → exactly 3 attempts of entry 5, then error=1, err_index=5, done=0, sda_oe=0, scl_out=1.
- With CLK_DIV=4: check SDA is stable across every SCL high phase except START (SDA falls while SCL=1) and STOP (SDA rises while SCL=1). Check the SCL period is 16 clks.
- Pulse start mid-sequence → ignored, no restart. Pulse start after done → done clears, busy rises, full 10-entry sequence repeats.
- Assert reset_n=0 during entry 4 bit 3 → scl_out=1, sda_oe=0, busy=0 asynchronously, before the next clk edge. Release → fresh run starting from entry 0.

Source files
------------

// File: rtl/wm8731_i2c_config.sv
// One-shot I2C configuration master for the WM8731 codec: writes a fixed
// 10-entry register table, retrying entries on NACK and reporting busy/done/error.
module wm8731_i2c_config #(
    parameter int         CLK_DIV   = 125,
    parameter logic [6:0] DEV_ADDR  = 7'h1A,
    parameter int         MAX_RETRY = 3,
    parameter int         GAP_CYC   = 500
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       sda_in,
    output logic       scl_out,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] err_index
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        IDLE, START, BYTE, ACK, STOP, GAP, DONE, ERROR
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       q;
    logic [2:0]       bit_cnt;
    logic [1:0]       byte_cnt;
    logic [7:0]       shreg;
    logic [3:0]       index;
    logic [RTY_W-1:0] retry;
    logic [GAP_W-1:0] gap_cnt;
    logic             xfer_ok;
    logic             arm;
    logic             qtick;

    assign qtick = (div_cnt == DIV_W'(CLK_DIV - 1));

    // Register word layout is {reg[6:0], data[8:0]}.
    function automatic logic [15:0] table_word(input logic [3:0] idx);
        case (idx)
            4'd0:    table_word = {7'd15, 9'h000};
            4'd1:    table_word = {7'd0,  9'h017};
            4'd2:    table_word = {7'd1,  9'h017};
            4'd3:    table_word = {7'd2,  9'h079};
            4'd4:    table_word = {7'd3,  9'h079};
            4'd5:    table_word = {7'd4,  9'h012};
            4'd6:    table_word = {7'd5,  9'h000};
            4'd7:    table_word = {7'd6,  9'h000};
            4'd8:    table_word = {7'd7,  9'h042};
            4'd9:    table_word = {7'd9,  9'h001};
            default: table_word = 16'h0000;
        endcase
    endfunction

    function automatic logic [7:0] load_byte(input logic [1:0] sel, input logic [3:0] idx);
        logic [15:0] w;
        w = table_word(idx);
        case (sel)
            2'd0:    load_byte = {DEV_ADDR, 1'b0};
            2'd1:    load_byte = w[15:8];
            default: load_byte = w[7:0];
        endcase
    endfunction

    // Every bus phase is a 4-qtick cell; q tracks the position inside the cell.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            q         <= 2'd0;
            bit_cnt   <= 3'd0;
            byte_cnt  <= 2'd0;
            shreg     <= 8'h00;
            index     <= 4'd0;
            retry     <= '0;
            gap_cnt   <= '0;
            xfer_ok   <= 1'b0;
            arm       <= 1'b1;
            scl_out   <= 1'b1;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_index <= 4'd0;
        end else begin
            div_cnt <= qtick ? '0 : div_cnt + 1'b1;
            case (state)
                IDLE: begin
                    scl_out <= 1'b1;
                    sda_oe  <= 1'b0;
                    if (start || arm) begin
                        arm     <= 1'b0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        error   <= 1'b0;
                        index   <= 4'd0;
                        retry   <= '0;
                        q       <= 2'd0;
                        div_cnt <= '0;
                        state   <= START;
                    end
                end
                START: if (qtick) begin
                    q <= q + 2'd1;
                    case (q)
                        2'd0: begin scl_out <= 1'b1; sda_oe <= 1'b0; end
                        2'd1: sda_oe  <= 1'b1;
                        2'd2: scl_out <= 1'b0;
                        2'd3: begin
                            shreg    <= load_byte(2'd0, index);
                            byte_cnt <= 2'd0;
                            bit_cnt  <= 3'd0;
                            state    <= BYTE;
                        end
                    endcase
                end
                BYTE: if (qtick) begin
                    q <= q + 2'd1;
                    case (q)
                        2'd0: begin scl_out <= 1'b0; sda_oe <= ~shreg[7]; end
                        2'd2: scl_out <= 1'b1;
                        2'd3: begin
                            shreg   <= {shreg[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                state <= ACK;
                        end
                        default: ;
                    endcase
                end
                ACK: if (qtick) begin
                    q <= q + 2'd1;
                    case (q)
                        2'd0: begin scl_out <= 1'b0; sda_oe <= 1'b0; end
                        2'd2: scl_out <= 1'b1;
                        2'd3: begin
                            if (sda_in) begin
                                xfer_ok <= 1'b0;
                                state   <= STOP;
                            end else if (byte_cnt == 2'd2) begin
                                xfer_ok <= 1'b1;
                                state   <= STOP;
                            end else begin
                                byte_cnt <= byte_cnt + 2'd1;
                                shreg    <= load_byte(byte_cnt + 2'd1, index);
                                bit_cnt  <= 3'd0;
                                state    <= BYTE;
                            end
                        end
                        default: ;
                    endcase
                end
                STOP: if (qtick) begin
                    q <= q + 2'd1;
                    case (q)
                        2'd0: begin scl_out <= 1'b0; sda_oe <= 1'b1; end
                        2'd2: scl_out <= 1'b1;
                        2'd3: begin
                            sda_oe  <= 1'b0;
                            gap_cnt <= '0;
                            state   <= GAP;
                        end
                        default: ;
                    endcase
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                        q       <= 2'd0;
                        div_cnt <= '0;
                        if (xfer_ok && index == 4'd9) begin
                            state <= DONE;
                        end else if (xfer_ok) begin
                            index <= index + 4'd1;
                            retry <= '0;
                            state <= START;
                        end else if (int'(retry) + 1 < MAX_RETRY) begin
                            retry <= retry + 1'b1;
                            state <= START;
                        end else begin
                            err_index <= index;
                            state     <= ERROR;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                ERROR: begin
                    busy  <= 1'b0;
                    error <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wm8731_i2c_config.sv
// Bench for wm8731_i2c_config: an I2C slave model decodes every write on the bus
// and is steered to NACK selected bytes; decoded traffic is compared to a vector table.
module tb_wm8731_i2c_config;

    localparam int CLK_DIV_TB = 4;
    localparam int GAP_TB     = 20;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       sda_in;
    logic       scl_out;
    logic       sda_oe;
    logic       busy;
    logic       done;
    logic       error;
    logic [3:0] err_index;

    logic slave_drive;
    logic sda_line;
    assign sda_line = ~(sda_oe | slave_drive);
    assign sda_in   = sda_line;

    wm8731_i2c_config #(
        .CLK_DIV  (CLK_DIV_TB),
        .DEV_ADDR (7'h1A),
        .MAX_RETRY(3),
        .GAP_CYC  (GAP_TB)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .sda_in   (sda_in),
        .scl_out  (scl_out),
        .sda_oe   (sda_oe),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_index(err_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         entry;
        logic [7:0] addr;
        logic [7:0] hi;
        logic [7:0] lo;
    } vec_t;

    vec_t vecs [10];

    int checks = 0;
    int errors = 0;

    // Slave-model state, written only by the slave process below.
    logic [7:0] tr_b [0:63][0:2];
    int         tr_n [0:63];
    int         tr_cnt, ok_count, nacks_given;
    int         bus_err, period_err, period_checks;
    int         bitcnt, byte_idx;
    bit         in_xfer, cur_nack, have_rise;
    logic [7:0] sh;
    logic       prev_scl, prev_sda;
    longint     cycle, last_rise;
    int         clear_ack;

    // Control written only by the main sequence.
    int clear_req   = 0;
    int nack_entry  = -1;
    int nack_byte   = 0;
    int nack_limit  = 0;

    initial begin
        slave_drive = 1'b0;
        clear_ack = 0; tr_cnt = 0; ok_count = 0; nacks_given = 0;
        bus_err = 0; period_err = 0; period_checks = 0;
        bitcnt = 0; byte_idx = 0; in_xfer = 0; cur_nack = 0; have_rise = 0;
        sh = 8'h00; prev_scl = 1'b1; prev_sda = 1'b1; cycle = 0; last_rise = 0;
        forever begin
            @(negedge clk);
            cycle++;
            if (!reset_n || clear_req != clear_ack) begin
                clear_ack = clear_req;
                tr_cnt = 0; ok_count = 0; nacks_given = 0;
                bus_err = 0; period_err = 0; period_checks = 0;
                bitcnt = 0; byte_idx = 0; in_xfer = 0; cur_nack = 0; have_rise = 0;
                slave_drive = 1'b0;
            end else if (prev_scl && scl_out && prev_sda != sda_line) begin
                if (!sda_line) begin
                    if (in_xfer) bus_err++;
                    in_xfer = 1; bitcnt = 0; byte_idx = 0; cur_nack = 0; have_rise = 0;
                end else begin
                    if (!in_xfer || bitcnt != 1) bus_err++;
                    if (in_xfer && tr_cnt < 64) begin
                        tr_n[tr_cnt] = byte_idx;
                        tr_cnt++;
                        if (byte_idx == 3 && !cur_nack) ok_count++;
                    end
                    in_xfer = 0;
                end
            end else if (in_xfer && !prev_scl && scl_out) begin
                if (have_rise) begin
                    period_checks++;
                    if (cycle - last_rise != longint'(4 * CLK_DIV_TB)) period_err++;
                end
                have_rise = 1;
                last_rise = cycle;
                if (bitcnt < 8) sh = {sh[6:0], sda_line};
                bitcnt++;
            end else if (in_xfer && prev_scl && !scl_out) begin
                if (bitcnt == 8) begin
                    if (tr_cnt < 64 && byte_idx < 3) tr_b[tr_cnt][byte_idx] = sh;
                    if (ok_count == nack_entry && byte_idx == nack_byte && nacks_given < nack_limit) begin
                        nacks_given++;
                        cur_nack = 1;
                        slave_drive = 1'b0;
                    end else begin
                        slave_drive = 1'b1;
                    end
                end else if (bitcnt == 9) begin
                    slave_drive = 1'b0;
                    bitcnt = 0;
                    byte_idx++;
                end
            end
            prev_scl = scl_out;
            prev_sda = sda_line;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clearLog();
        clear_req++;
        repeat (2) @(negedge clk);
    endtask

    task automatic waitFinish(input int budget);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while (!(!busy && (done || error)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("finish_in_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic checkTrans(input int k, input int e);
        checkOutput($sformatf("t%0d_nbytes", k), tr_n[k], 32'd3);
        checkOutput($sformatf("t%0d_addr", k), 32'(tr_b[k][0]), 32'(vecs[e].addr));
        checkOutput($sformatf("t%0d_hi", k), 32'(tr_b[k][1]), 32'(vecs[e].hi));
        checkOutput($sformatf("t%0d_lo", k), 32'(tr_b[k][2]), 32'(vecs[e].lo));
    endtask

    initial begin
        vecs[0] = '{0, 8'h34, 8'h1E, 8'h00};
        vecs[1] = '{1, 8'h34, 8'h00, 8'h17};
        vecs[2] = '{2, 8'h34, 8'h02, 8'h17};
        vecs[3] = '{3, 8'h34, 8'h04, 8'h79};
        vecs[4] = '{4, 8'h34, 8'h06, 8'h79};
        vecs[5] = '{5, 8'h34, 8'h08, 8'h12};
        vecs[6] = '{6, 8'h34, 8'h0A, 8'h00};
        vecs[7] = '{7, 8'h34, 8'h0C, 8'h00};
        vecs[8] = '{8, 8'h34, 8'h0E, 8'h42};
        vecs[9] = '{9, 8'h34, 8'h12, 8'h01};

        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_scl", 32'(scl_out), 32'd1);
        checkOutput("rst_sda_oe", 32'(sda_oe), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        checkOutput("rst_err_index", 32'(err_index), 32'd0);

        $display("[TB] run 1: auto-arm after reset, slave always ACKs");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("autoarm_busy", 32'(busy), 32'd1);
        waitFinish(8000);
        checkOutput("run1_done", 32'(done), 32'd1);
        checkOutput("run1_error", 32'(error), 32'd0);
        checkOutput("run1_busy", 32'(busy), 32'd0);
        checkOutput("run1_trans", tr_cnt, 32'd10);
        for (int i = 0; i < 10; i++) checkTrans(i, vecs[i].entry);
        checkOutput("run1_bus_rules", bus_err, 32'd0);
        checkOutput("run1_scl_period_errs", period_err, 32'd0);
        checkOutput("run1_scl_period_count", period_checks, 32'd270);

        $display("[TB] run 2: restart after done, one NACK on entry 3 byte 1, stray start mid-run");
        nack_entry = 3; nack_byte = 1; nack_limit = 1;
        clearLog();
        applyStimulus();
        checkOutput("restart_done_clear", 32'(done), 32'd0);
        checkOutput("restart_busy", 32'(busy), 32'd1);
        repeat (1500) @(negedge clk);
        applyStimulus();
        waitFinish(9000);
        checkOutput("run2_done", 32'(done), 32'd1);
        checkOutput("run2_error", 32'(error), 32'd0);
        checkOutput("run2_trans", tr_cnt, 32'd11);
        checkOutput("run2_nacks", nacks_given, 32'd1);
        checkOutput("run2_partial_n", tr_n[3], 32'd2);
        checkOutput("run2_partial_hi", 32'(tr_b[3][1]), 32'h04);
        for (int k = 0; k < 11; k++)
            if (k != 3) checkTrans(k, (k < 3) ? k : k - 1);
        checkOutput("run2_bus_rules", bus_err, 32'd0);

        $display("[TB] run 3: entry 5 address always NACKed");
        nack_entry = 5; nack_byte = 0; nack_limit = 1000;
        clearLog();
        applyStimulus();
        waitFinish(8000);
        checkOutput("run3_error", 32'(error), 32'd1);
        checkOutput("run3_err_index", 32'(err_index), 32'd5);
        checkOutput("run3_done", 32'(done), 32'd0);
        checkOutput("run3_busy", 32'(busy), 32'd0);
        checkOutput("run3_sda_oe", 32'(sda_oe), 32'd0);
        checkOutput("run3_scl", 32'(scl_out), 32'd1);
        checkOutput("run3_trans", tr_cnt, 32'd8);
        checkOutput("run3_nacks", nacks_given, 32'd3);
        for (int k = 5; k < 8; k++)
            checkOutput($sformatf("run3_t%0d_n", k), tr_n[k], 32'd1);

        $display("[TB] run 4: reset during entry 4 bit 3");
        nack_entry = -1; nack_limit = 0;
        clearLog();
        applyStimulus();
        begin
            int n;
            n = 0;
            while (!(ok_count == 4 && in_xfer && byte_idx == 0 && bitcnt == 3) && n < 5000) begin
                @(negedge clk);
                n++;
            end
            checkOutput("reach_entry4_bit3", 32'(n < 5000), 32'd1);
        end
        checkOutput("pre_abort_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("abort_scl", 32'(scl_out), 32'd1);
        checkOutput("abort_sda_oe", 32'(sda_oe), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        waitFinish(8000);
        checkOutput("run4_done", 32'(done), 32'd1);
        checkOutput("run4_trans", tr_cnt, 32'd10);
        checkTrans(0, 0);
        checkTrans(9, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
